// File: rtl/regfile_2r1w_clr.sv
// regfile_2r1w_clr: DEPTH x DATA_W register file, one byte-enabled write
// port, two registered read ports (write-first bypass), bulk-clear engine.
// Ports: clk, rst (async, active high); we/waddr/wdata/wbe write port;
// re_a/raddr_a/rdata_a and re_b/raddr_b/rdata_b read ports;
// clr_req starts the sequential clear, busy is high while it runs.
module regfile_2r1w_clr #(
   parameter int                DATA_W    = 32,
   parameter int                ADDR_W    = 4,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   wbe,
   input  logic                  re_a,
   input  logic [ADDR_W-1:0]     raddr_a,
   output logic [DATA_W-1:0]     rdata_a,
   input  logic                  re_b,
   input  logic [ADDR_W-1:0]     raddr_b,
   output logic [DATA_W-1:0]     rdata_b,
   input  logic                  clr_req,
   output logic                  busy
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int NBYTE = DATA_W/8;

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_CLEAR = 1'b1;

   logic [0:0]        state;
   logic [ADDR_W-1:0] cnt;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              clearing;
   logic              wr_ok;
   logic              last;
   logic [DATA_W-1:0] wr_val;
   logic [DATA_W-1:0] nxt_a;
   logic [DATA_W-1:0] nxt_b;

   assign clearing = (state == S_CLEAR);
   assign busy     = clearing;
   assign wr_ok    = we && !clearing;
   assign last     = (cnt == ADDR_W'(DEPTH-1));

   // Merged post-write word: new bytes where enabled, old bytes elsewhere.
   always_comb begin
      wr_val = mem[waddr];
      for (int k = 0; k < NBYTE; k++) begin
         if (wbe[k]) wr_val[8*k +: 8] = wdata[8*k +: 8];
      end
   end

   // Read mux with bypass; the clear write and a user write never
   // coexist, so priority order between them does not matter.
   always_comb begin
      nxt_a = mem[raddr_a];
      if (wr_ok && raddr_a == waddr) nxt_a = wr_val;
      if (clearing && raddr_a == cnt) nxt_a = RESET_VAL;
   end

   always_comb begin
      nxt_b = mem[raddr_b];
      if (wr_ok && raddr_b == waddr) nxt_b = wr_val;
      if (clearing && raddr_b == cnt) nxt_b = RESET_VAL;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
      end else if (clearing) begin
         mem[cnt] <= RESET_VAL;
      end else if (we) begin
         mem[waddr] <= wr_val;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (clr_req) begin
                  state <= S_CLEAR;
                  cnt   <= '0;
               end
            end
            S_CLEAR: begin
               cnt <= cnt + 1'b1;
               if (last) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_a <= '0;
         rdata_b <= '0;
      end else begin
         if (re_a) rdata_a <= nxt_a;
         if (re_b) rdata_b <= nxt_b;
      end
   end

endmodule
